toom_k_operand_splitter: RTL and testbench

- Parametrised successor to the fixed 8-way Toom operand splitter.
- Accepts one operand pair (X, Y) per transaction over a valid/ready handshake.
- Splits both operands into K limbs of LIMB_W = OP_W/K bits, each extended by one bit (sign or zero, selectable per transaction).
- Streams limb pairs LSB-first, one pair per accepted beat, to the downstream evaluation stage.

---
 rtl/toom_k_operand_splitter_if.sv | 44 ++++
 rtl/toom_k_operand_splitter.sv | 158 +++++++++++++++
 tb/tb_toom_k_operand_splitter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/toom_k_operand_splitter_if.sv
// Operand-in / limb-out handshake bundle for the Toom-K operand splitter.
// Carries the optional running-sum ports when TOOM_SPLIT_LIMB_SUM_EN is defined.
interface toom_k_operand_splitter_if #(
    parameter int OP_W = 1024,
    parameter int K    = 8
);
    localparam int LIMB_W = OP_W / K;
    localparam int IDX_W  = $clog2(K);
    localparam int SUM_W  = LIMB_W + 1 + IDX_W;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_x;
    logic [OP_W-1:0]   in_y;
    logic              in_sign;
    logic              out_valid;
    logic              out_ready;
    logic [LIMB_W:0]   out_a;
    logic [LIMB_W:0]   out_b;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
`ifdef TOOM_SPLIT_LIMB_SUM_EN
    logic [SUM_W-1:0]  out_sum_a;
    logic [SUM_W-1:0]  out_sum_b;

    modport master (
        output in_valid, in_x, in_y, in_sign, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_idx, out_last, out_sum_a, out_sum_b
    );
    modport slave (
        input  in_valid, in_x, in_y, in_sign, out_ready,
        output in_ready, out_valid, out_a, out_b, out_idx, out_last, out_sum_a, out_sum_b
    );
`else
    modport master (
        output in_valid, in_x, in_y, in_sign, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_idx, out_last
    );
    modport slave (
        input  in_valid, in_x, in_y, in_sign, out_ready,
        output in_ready, out_valid, out_a, out_b, out_idx, out_last
    );
`endif
endinterface

// File: rtl/toom_k_operand_splitter.sv
// Splits an operand pair into K sign/zero-extended limbs and streams them LSB-first.
// Optional feature macro: TOOM_SPLIT_LIMB_SUM_EN adds running A(1)/B(1) sum outputs.
module toom_k_operand_splitter #(
    parameter int OP_W = 1024,
    parameter int K    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    toom_k_operand_splitter_if.slave bus
);
    localparam int LIMB_W = OP_W / K;
    localparam int IDX_W  = $clog2(K);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

    if (K < 2 || (OP_W % K) != 0) begin : g_bad_cfg
        $fatal(1, "toom_k_operand_splitter: K must be >= 2 and divide OP_W");
    end

    typedef enum logic {IDLE, STREAM} state_e;

    state_e                   state_q, state_d;
    logic [K-1:0][LIMB_W-1:0] a_q, a_d, b_q, b_d;
    logic                     sign_q, sign_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic [LIMB_W:0]          out_a_q, out_a_d, out_b_q, out_b_d;

    logic [K-1:0][LIMB_W-1:0] in_x_limbs, in_y_limbs;
    logic                     in_accept, beat_accept;
    logic [IDX_W-1:0]         nxt_idx;

    assign in_x_limbs  = bus.in_x;
    assign in_y_limbs  = bus.in_y;
    assign in_accept   = bus.in_valid & in_ready_q;
    assign beat_accept = out_valid_q & bus.out_ready;
    assign nxt_idx     = idx_q + IDX_W'(1);

    function automatic logic [LIMB_W:0] ext_limb(input logic [LIMB_W-1:0] l, input logic s);
        return {s & l[LIMB_W-1], l};
    endfunction

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sign_d      = sign_q;
        idx_d       = idx_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_accept) begin
                    a_d         = in_x_limbs;
                    b_d         = in_y_limbs;
                    sign_d      = bus.in_sign;
                    idx_d       = '0;
                    out_a_d     = ext_limb(in_x_limbs[0], bus.in_sign);
                    out_b_d     = ext_limb(in_y_limbs[0], bus.in_sign);
                    out_last_d  = 1'b0;
                    out_valid_d = 1'b1;
                    in_ready_d  = 1'b0;
                    state_d     = STREAM;
                end
            end
            STREAM: begin
                if (beat_accept) begin
                    if (out_last_q) begin
                        // in_ready rises with the return to IDLE, giving one idle slot per transaction
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        idx_d      = nxt_idx;
                        out_a_d    = ext_limb(a_q[nxt_idx], sign_q);
                        out_b_d    = ext_limb(b_q[nxt_idx], sign_q);
                        out_last_d = (nxt_idx == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sign_q      <= sign_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = out_last_q;

`ifdef TOOM_SPLIT_LIMB_SUM_EN
    localparam int SUM_W = LIMB_W + 1 + IDX_W;

    logic [SUM_W-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
    logic [SUM_W-1:0] cur_a, cur_b;

    // The extension bit is already zero for unsigned transactions, so replicating it covers both cases.
    assign cur_a = {{IDX_W{sign_q & out_a_q[LIMB_W]}}, out_a_q};
    assign cur_b = {{IDX_W{sign_q & out_b_q[LIMB_W]}}, out_b_q};

    always_comb begin
        acc_a_d = acc_a_q;
        acc_b_d = acc_b_q;
        if (in_accept) begin
            acc_a_d = '0;
            acc_b_d = '0;
        end else if (beat_accept) begin
            acc_a_d = acc_a_q + cur_a;
            acc_b_d = acc_b_q + cur_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_a_q <= '0;
            acc_b_q <= '0;
        end else begin
            acc_a_q <= acc_a_d;
            acc_b_q <= acc_b_d;
        end
    end

    assign bus.out_sum_a = acc_a_q + cur_a;
    assign bus.out_sum_b = acc_b_q + cur_b;
`endif
endmodule

// File: tb/tb_toom_k_operand_splitter.sv
// Bench for toom_k_operand_splitter: scoreboard model on a 16-bit/K=4 instance plus
// directed checks on a default-parameter instance.
module tb_toom_k_operand_splitter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    toom_k_operand_splitter_if #(.OP_W(16), .K(4)) bus ();
    toom_k_operand_splitter_if #(.OP_W(1024), .K(8)) bw ();

    toom_k_operand_splitter #(.OP_W(16), .K(4)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    toom_k_operand_splitter u_big (.clk(clk), .rst(rst), .bus(bw));

    int errs   = 0;
    int checks = 0;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endfunction

    function automatic void chk_big(string nm, logic [128:0] got, logic [128:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endfunction

    function automatic void timeout(string nm);
        checks++;
        errs++;
        $display("FAIL %s: timed out waiting on DUT", nm);
    endfunction

    // Expected beat stream: limb i is a base-16 digit, signed digit value when in_sign=1.
    typedef struct {
        logic [4:0] a, b;
        logic [1:0] idx;
        logic       last;
        logic [6:0] sa, sb;
    } beat_t;
    beat_t q[$];
    logic  rst_last = 1'b0;
    logic  armed = 1'b0;

    function automatic void push_txn(logic [15:0] x, logic [15:0] y, logic s);
        int sa = 0;
        int sb = 0;
        for (int i = 0; i < 4; i++) begin
            beat_t e;
            int la = int'((x >> (4 * i)) & 16'hF);
            int lb = int'((y >> (4 * i)) & 16'hF);
            int va = (s && la >= 8) ? la - 16 : la;
            int vb = (s && lb >= 8) ? lb - 16 : lb;
            sa += va;
            sb += vb;
            e.a = 5'(va);
            e.b = 5'(vb);
            e.idx = 2'(i);
            e.last = (i == 3);
            e.sa = 7'(sa);
            e.sb = 7'(sb);
            q.push_back(e);
        end
    endfunction

    always @(posedge clk) begin
        rst_last <= rst;
        armed <= 1'b1;
        if (rst) q.delete();
        else begin
            if (bus.out_valid && bus.out_ready && q.size() != 0) void'(q.pop_front());
            if (bus.in_valid && bus.in_ready) push_txn(bus.in_x, bus.in_y, bus.in_sign);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("in_ready", bus.in_ready, (q.size() == 0 && !rst_last));
            chk("out_valid", bus.out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("out_a", bus.out_a, q[0].a);
                chk("out_b", bus.out_b, q[0].b);
                chk("out_idx", bus.out_idx, q[0].idx);
                chk("out_last", bus.out_last, q[0].last);
`ifdef TOOM_SPLIT_LIMB_SUM_EN
                chk("out_sum_a", bus.out_sum_a, q[0].sa);
                chk("out_sum_b", bus.out_sum_b, q[0].sb);
`endif
            end
        end
    end

    logic [4:0] got_a[4], got_b[4];
    logic [1:0] got_idx[4];
    logic       got_last[4];
    logic [6:0] got_sa[4];

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic s);
        int n = 0;
        bus.in_x = x;
        bus.in_y = y;
        bus.in_sign = s;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) timeout("send");
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(input int stall_beat, input int stall_n, output int cyc);
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            while (!bus.out_valid && n < 20) begin
                @(negedge clk);
                n++;
                cyc++;
            end
            if (!bus.out_valid) begin
                timeout("collect");
                return;
            end
            got_a[i] = bus.out_a;
            got_b[i] = bus.out_b;
            got_idx[i] = bus.out_idx;
            got_last[i] = bus.out_last;
`ifdef TOOM_SPLIT_LIMB_SUM_EN
            got_sa[i] = bus.out_sum_a;
`else
            got_sa[i] = '0;
`endif
            if (i == stall_beat) begin
                bus.out_ready = 1'b0;
                repeat (stall_n) begin
                    @(negedge clk);
                    cyc++;
                    chk("bp_valid", bus.out_valid, 1);
                    chk("bp_idx", bus.out_idx, i);
                end
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        logic [4:0] ea[4];
        logic [4:0] eb[4];
        logic [128:0] e0;

        rst = 1'b1;
        bus.in_valid = 0; bus.in_x = '0; bus.in_y = '0; bus.in_sign = 0; bus.out_ready = 1;
        bw.in_valid = 0; bw.in_x = '0; bw.in_y = '0; bw.in_sign = 0; bw.out_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_a", bus.out_a, 0);
        chk("rst_out_idx", bus.out_idx, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);

        // signed split of F00F / 1234
        send(16'hF00F, 16'h1234, 1'b1);
        collect(-1, 0, cyc);
        ea = '{5'h1F, 5'h00, 5'h00, 5'h1F};
        eb = '{5'h04, 5'h03, 5'h02, 5'h01};
        for (int i = 0; i < 4; i++) begin
            chk("t1_a", got_a[i], ea[i]);
            chk("t1_b", got_b[i], eb[i]);
            chk("t1_idx", got_idx[i], i);
        end
        chk("t1_last0", got_last[0], 0);
        chk("t1_last3", got_last[3], 1);
        chk("t1_cycles", cyc, 4);
`ifdef TOOM_SPLIT_LIMB_SUM_EN
        chk("t1_sum", got_sa[3], 7'h7E);
`endif

        // unsigned split of the same operands
        send(16'hF00F, 16'h1234, 1'b0);
        collect(-1, 0, cyc);
        ea = '{5'h0F, 5'h00, 5'h00, 5'h0F};
        for (int i = 0; i < 4; i++) chk("t2_a", got_a[i], ea[i]);
`ifdef TOOM_SPLIT_LIMB_SUM_EN
        chk("t2_sum", got_sa[3], 7'h1E);
`endif

        // back-pressure on beat 1 for three cycles
        send(16'hA5C3, 16'h7E81, 1'b1);
        collect(1, 3, cyc);
        chk("t3_cycles", cyc, 7);

        // reset at beat 2 drops the transaction
        send(16'h8421, 16'hFFFF, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("t4_idx_before_rst", bus.out_idx, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_valid_after_rst", bus.out_valid, 0);
        chk("t4_ready_in_rst", bus.in_ready, 0);
        @(negedge clk);
        chk("t4_ready_after_rst", bus.in_ready, 1);
        send(16'h1357, 16'h2468, 1'b0);
        collect(-1, 0, cyc);
        chk("t4_new_idx0", got_idx[0], 0);
        chk("t4_new_a0", got_a[0], 5'h07);

        // in_valid held with new operands during STREAM
        send(16'h0F0F, 16'hF0F0, 1'b1);
        bus.in_x = 16'hBEEF; bus.in_y = 16'hCAFE; bus.in_sign = 1'b0; bus.in_valid = 1'b1;
        collect(-1, 0, cyc);
        ea = '{5'h1F, 5'h00, 5'h1F, 5'h00};
        for (int i = 0; i < 4; i++) chk("t5_a", got_a[i], ea[i]);
        chk("t5_idle_ready", bus.in_ready, 1);
        chk("t5_idle_valid", bus.out_valid, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("t5_new_valid", bus.out_valid, 1);
        collect(-1, 0, cyc);
        ea = '{5'h0F, 5'h0E, 5'h0E, 5'h0B};
        for (int i = 0; i < 4; i++) chk("t5_new_a", got_a[i], ea[i]);

        // default parameters: only bit 127 set, signed
        e0 = '0;
        e0[128] = 1'b1;
        e0[127] = 1'b1;
        bw.in_x[127] = 1'b1;
        bw.in_sign = 1'b1;
        bw.in_valid = 1'b1;
        chk("big_ready", bw.in_ready, 1);
        @(negedge clk);
        bw.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int n = 0;
            while (!bw.out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!bw.out_valid) begin
                timeout("big_beat");
                break;
            end
            chk_big("big_a", bw.out_a, (i == 0) ? e0 : 129'd0);
            chk_big("big_b", bw.out_b, 129'd0);
            chk("big_idx", bw.out_idx, i);
            chk("big_last", bw.out_last, i == 7);
            @(negedge clk);
        end
        chk("big_done_valid", bw.out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
